// File: rtl/fp_addsub_pkg.sv
// Shared types and helpers for the pipelined aligned-significand adder.
package fp_addsub_pkg;
  localparam int GRS_W      = 3;
  localparam int MANT_W_DEF = 24;
  localparam int EXP_W_DEF  = 8;
  localparam int EXT_W_DEF  = MANT_W_DEF + GRS_W;

  function automatic int ext_w(input int mant_w);
    return mant_w + GRS_W;
  endfunction

  // Single-precision reference layouts; the top re-declares them at its own widths.
  typedef struct packed {
    logic [EXT_W_DEF-1:0] ext_a;
    logic [EXT_W_DEF-1:0] ext_b;
    logic                 eff_sub;
    logic                 a_ge_b;
    logic                 sign_a;
    logic                 sb;
    logic [EXP_W_DEF-1:0] exp;
  } s1_t;

  typedef struct packed {
    logic [MANT_W_DEF-1:0] mant;
    logic [GRS_W-1:0]      grs;
    logic                  carry;
    logic                  sign;
    logic                  zero;
    logic                  eff_sub;
    logic [EXP_W_DEF-1:0]  exp;
  } res_t;
endpackage

// File: rtl/fp_pipe_stage.sv
// Generic valid/ready register slice; 1 cycle, loads only when adv is high.
// Data registers hold when the incoming beat is not valid.
module fp_pipe_stage #(
  parameter int  W = 1,
  parameter type T = logic [W-1:0]
) (
  input  logic clk,
  input  logic reset,
  input  logic adv,
  input  logic in_valid,
  input  T     d,
  output logic valid,
  output T     q
);
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (adv) begin
      valid <= in_valid;
      if (in_valid) q <= d;
    end
  end
endmodule

// File: rtl/fp_signif_addsub_pipe.sv
// Aligned-significand add/subtract, 2-stage valid/ready pipeline, full backpressure.
// Optional op counters under FPADD_OP_STATS_EN.
module fp_signif_addsub_pipe
  import fp_addsub_pkg::*;
#(
  parameter int MANT_W = 24,
  parameter int EXP_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              op_sub,
  input  logic              sign_a,
  input  logic              sign_b,
  input  logic [EXP_W-1:0]  exp_a,
  input  logic [EXP_W-1:0]  exp_b,
  input  logic [MANT_W-1:0] mant_a,
  input  logic [MANT_W-1:0] mant_b,
  input  logic [2:0]        grs_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MANT_W-1:0] res_mant,
  output logic [2:0]        res_grs,
  output logic              res_carry,
  output logic              res_sign,
  output logic              res_zero,
`ifdef FPADD_OP_STATS_EN
  output logic [31:0]       stat_add,
  output logic [31:0]       stat_sub,
  output logic [31:0]       stat_cancel,
`endif
  output logic [EXP_W-1:0]  res_exp
);
  localparam int EW = ext_w(MANT_W);

  typedef struct packed {
    logic [EW-1:0]    ext_a;
    logic [EW-1:0]    ext_b;
    logic             eff_sub;
    logic             a_ge_b;
    logic             sign_a;
    logic             sb;
    logic [EXP_W-1:0] exp;
  } s1_w_t;

  typedef struct packed {
    logic [MANT_W-1:0] mant;
    logic [GRS_W-1:0]  grs;
    logic              carry;
    logic              sign;
    logic              zero;
    logic              eff_sub;
    logic [EXP_W-1:0]  exp;
  } res_w_t;

  s1_w_t  s1_d, s1_q;
  res_w_t res_d, res_q;
  logic   s1_v, s2_v, adv1, adv2;
  logic [EW:0]   sum;
  logic [EW-1:0] diff, ext;

  assign adv2      = !s2_v || out_ready;
  assign adv1      = !s1_v || adv2;
  assign in_ready  = adv1;
  assign out_valid = s2_v;

  // GRS belongs to the operand that was shifted; equal exponents mean neither was.
  always_comb begin
    s1_d         = '0;
    s1_d.ext_a   = {mant_a, (exp_a < exp_b) ? grs_in : {GRS_W{1'b0}}};
    s1_d.ext_b   = {mant_b, (exp_b < exp_a) ? grs_in : {GRS_W{1'b0}}};
    s1_d.sb      = sign_b ^ op_sub;
    s1_d.sign_a  = sign_a;
    s1_d.eff_sub = sign_a ^ s1_d.sb;
    s1_d.a_ge_b  = s1_d.ext_a >= s1_d.ext_b;
    s1_d.exp     = (exp_a >= exp_b) ? exp_a : exp_b;
  end

  fp_pipe_stage #(.W($bits(s1_w_t)), .T(s1_w_t)) u_s1 (
    .clk(clk), .reset(reset), .adv(adv1), .in_valid(in_valid),
    .d(s1_d), .valid(s1_v), .q(s1_q)
  );

  always_comb begin
    res_d   = '0;
    sum     = {1'b0, s1_q.ext_a} + {1'b0, s1_q.ext_b};
    diff    = s1_q.a_ge_b ? (s1_q.ext_a - s1_q.ext_b) : (s1_q.ext_b - s1_q.ext_a);
    ext     = s1_q.eff_sub ? diff : sum[EW-1:0];
    res_d.mant    = ext[EW-1:GRS_W];
    res_d.grs     = ext[GRS_W-1:0];
    res_d.carry   = !s1_q.eff_sub && sum[EW];
    res_d.zero    = (ext == '0);
    res_d.eff_sub = s1_q.eff_sub;
    res_d.exp     = s1_q.exp;
    if (!s1_q.eff_sub)
      res_d.sign = s1_q.sign_a;
    else if (res_d.zero)
      res_d.sign = s1_q.sign_a & s1_q.sb;  // exact cancellation gives +0 under RNE
    else
      res_d.sign = s1_q.a_ge_b ? s1_q.sign_a : s1_q.sb;
  end

  fp_pipe_stage #(.W($bits(res_w_t)), .T(res_w_t)) u_s2 (
    .clk(clk), .reset(reset), .adv(adv2), .in_valid(s1_v),
    .d(res_d), .valid(s2_v), .q(res_q)
  );

  assign res_mant  = res_q.mant;
  assign res_grs   = res_q.grs;
  assign res_carry = res_q.carry;
  assign res_sign  = res_q.sign;
  assign res_zero  = res_q.zero;
  assign res_exp   = res_q.exp;

`ifdef FPADD_OP_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_add    <= '0;
      stat_sub    <= '0;
      stat_cancel <= '0;
    end else if (s2_v && out_ready) begin
      if (!res_q.eff_sub && stat_add != '1) stat_add <= stat_add + 32'd1;
      if (res_q.eff_sub && stat_sub != '1) stat_sub <= stat_sub + 32'd1;
      if (res_q.eff_sub && res_q.zero && stat_cancel != '1) stat_cancel <= stat_cancel + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_fp_signif_addsub_pipe.sv
// Scoreboard bench for fp_signif_addsub_pipe: directed vectors, queued expectations, decoupled monitor.
module tb_fp_signif_addsub_pipe;
  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, op_sub, sign_a, sign_b;
  logic [7:0]  exp_a, exp_b, res_exp;
  logic [23:0] mant_a, mant_b, res_mant;
  logic [2:0]  grs_in, res_grs;
  logic        out_valid, out_ready, res_carry, res_sign, res_zero;
`ifdef FPADD_OP_STATS_EN
  logic [31:0] stat_add, stat_sub, stat_cancel;
  int          exp_add = 0, exp_sub = 0, exp_cancel = 0;
`endif

  always #5 clk = ~clk;

  fp_signif_addsub_pipe #(.MANT_W(24), .EXP_W(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op_sub(op_sub), .sign_a(sign_a), .sign_b(sign_b),
    .exp_a(exp_a), .exp_b(exp_b), .mant_a(mant_a), .mant_b(mant_b), .grs_in(grs_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .res_mant(res_mant), .res_grs(res_grs), .res_carry(res_carry),
    .res_sign(res_sign), .res_zero(res_zero),
`ifdef FPADD_OP_STATS_EN
    .stat_add(stat_add), .stat_sub(stat_sub), .stat_cancel(stat_cancel),
`endif
    .res_exp(res_exp)
  );

  typedef struct packed {
    logic [23:0] mant;
    logic [2:0]  grs;
    logic        carry;
    logic        sign;
    logic        zero;
    logic [7:0]  exp;
  } exp_t;

  typedef struct {
    logic sa, sb, op;
    logic [7:0]  ea, eb;
    logic [23:0] ma, mb;
    logic [2:0]  g;
    exp_t        x;
    logic        eff;
  } vec_t;

  vec_t vt[7];
  exp_t sb_q[$];
  logic eff_q[$];
  int   tests = 0, fails = 0;

  function automatic vec_t mk(input logic sa, sb, op, input logic [7:0] ea, eb,
                              input logic [23:0] ma, mb, input logic [2:0] g,
                              input logic [23:0] xm, input logic [2:0] xg,
                              input logic xc, xs, xz, input logic [7:0] xe, input logic eff);
    vec_t v;
    v.sa = sa; v.sb = sb; v.op = op; v.ea = ea; v.eb = eb;
    v.ma = ma; v.mb = mb; v.g = g;
    v.x = '{mant: xm, grs: xg, carry: xc, sign: xs, zero: xz, exp: xe};
    v.eff = eff;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  task automatic send(input int i);
    int n;
    in_valid = 1'b1;
    sign_a = vt[i].sa; sign_b = vt[i].sb; op_sub = vt[i].op;
    exp_a = vt[i].ea; exp_b = vt[i].eb;
    mant_a = vt[i].ma; mant_b = vt[i].mb; grs_in = vt[i].g;
    #1;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      #1;
      n++;
    end
    if (n == 50) begin
      tests++; fails++;
      $display("FAIL send_timeout: vector %0d never accepted, in_ready %0b", i, in_ready);
    end else begin
      sb_q.push_back(vt[i].x);
      eff_q.push_back(vt[i].eff);
    end
    tick();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    chk("drain_pending", 64'(sb_q.size()), 64'd0);
  endtask

  // Monitor: pops on every output handshake and checks stall stability.
  exp_t act, held, e;
  logic held_pend = 1'b0;
  logic eff;
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      act = '{mant: res_mant, grs: res_grs, carry: res_carry, sign: res_sign,
              zero: res_zero, exp: res_exp};
      if (held_pend) begin
        tests++;
        if (act !== held) begin
          fails++;
          $display("FAIL hold_stable: got %0h, expected %0h", act, held);
        end
      end
      if (out_ready) begin
        tests++;
        if (sb_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_output: got %0h, expected no output", act);
        end else begin
          e   = sb_q.pop_front();
          eff = eff_q.pop_front();
          if (act !== e) begin
            fails++;
            $display("FAIL result: got %0h, expected %0h", act, e);
          end
`ifdef FPADD_OP_STATS_EN
          if (!eff) exp_add++;
          else begin
            exp_sub++;
            if (e.zero) exp_cancel++;
          end
`endif
        end
        held_pend = 1'b0;
      end else begin
        held      = act;
        held_pend = 1'b1;
      end
    end else begin
      held_pend = 1'b0;
    end
  end

  initial begin
    //          sa sb op  ea   eb   ma        mb        g     mant      grs  c  s  z  exp  eff
    vt[0] = mk(0, 0, 0, 127, 127, 24'h800000, 24'h800000, 3'b000, 24'h000000, 3'b000, 1, 0, 1, 127, 0);
    vt[1] = mk(0, 1, 0, 128, 127, 24'h800000, 24'h400000, 3'b100, 24'h3FFFFF, 3'b100, 0, 0, 0, 128, 1);
    vt[2] = mk(0, 0, 1, 127, 128, 24'h400000, 24'h800000, 3'b011, 24'h3FFFFF, 3'b101, 0, 1, 0, 128, 1);
    // equal mantissas: only B's GRS makes it the larger magnitude
    vt[3] = mk(0, 0, 1, 128, 127, 24'h400000, 24'h400000, 3'b011, 24'h000000, 3'b011, 0, 1, 0, 128, 1);
    vt[4] = mk(1, 1, 1, 130, 130, 24'h812345, 24'h812345, 3'b101, 24'h000000, 3'b000, 0, 0, 1, 130, 1);
    vt[5] = mk(1, 0, 0, 130, 130, 24'h812345, 24'h812345, 3'b111, 24'h000000, 3'b000, 0, 0, 1, 130, 1);
    vt[6] = mk(1, 1, 0, 100,  98, 24'h900000, 24'h200000, 3'b010, 24'hB00000, 3'b010, 0, 1, 0, 100, 0);

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    op_sub = 0; sign_a = 0; sign_b = 0; exp_a = 0; exp_b = 0;
    mant_a = 0; mant_b = 0; grs_in = 0;
    repeat (3) tick();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_res", 64'({res_mant, res_grs, res_carry, res_sign, res_zero, res_exp}), 64'd0);
    reset = 1'b0;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
`ifdef FPADD_OP_STATS_EN
    chk("rst_stats", 64'(stat_add | stat_sub | stat_cancel), 64'd0);
`endif

    // Latency: accept edge, then one more edge before out_valid.
    send(0);
    in_valid = 1'b0;
    chk("lat_after_accept", 64'(out_valid), 64'd0);
    tick();
    chk("lat_two_edges", 64'(out_valid), 64'd1);
    drain();

    for (int i = 1; i <= 5; i++) send(i);
    in_valid = 1'b0;
    drain();

    // Back-to-back with a 3-cycle stall starting at the second output.
    fork
      begin
        send(6); send(1); send(3); send(0);
        in_valid = 1'b0;
      end
      begin
        repeat (3) tick();
        out_ready = 1'b0;
        #1;
        chk("stall_in_ready_low", 64'(in_ready), 64'd0);
        chk("stall_out_valid", 64'(out_valid), 64'd1);
        repeat (3) tick();
        out_ready = 1'b1;
      end
    join
    drain();
    tick();
`ifdef FPADD_OP_STATS_EN
    chk("stat_add", 64'(stat_add), 64'(exp_add));
    chk("stat_sub", 64'(stat_sub), 64'(exp_sub));
    chk("stat_cancel", 64'(stat_cancel), 64'(exp_cancel));
`endif

    // Reset with two transactions in flight.
    out_ready = 1'b0;
    send(0);
    send(1);
    in_valid = 1'b0;
    chk("inflight_out_valid", 64'(out_valid), 64'd1);
    reset = 1'b1;
    tick();
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    sb_q.delete();
    eff_q.delete();
    reset = 1'b0;
    out_ready = 1'b1;
    repeat (4) begin
      tick();
      chk("post_rst_no_output", 64'(out_valid), 64'd0);
    end
`ifdef FPADD_OP_STATS_EN
    chk("post_rst_stats", 64'(stat_add | stat_sub | stat_cancel), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fp_signif_addsub_pipe.md
Name: fp_signif_addsub_pipe

Overview:
Parametrised, pipelined successor to the combinational aligned-significand adder in the FP adder datapath. It sits between the alignment shifter and the normaliser/rounder. It takes two aligned significands plus the guard/round/sticky (GRS) bits of the shifted operand, and performs an effective add or subtract with correct magnitude ordering. It returns the result significand with its GRS bits, carry, sign and zero flag through a 2-stage valid/ready pipeline with full backpressure.

Parameters:
MANT_W, 24, significand width including hidden bit (11 for half, 53 for double)
EXP_W, 8, exponent width (5 half, 11 double)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high
in_valid  in  1  input transaction valid
in_ready  out  1  block can accept input this cycle
op_sub  in  1  1 = compute A - B (sign_b inverted internally), 0 = A + B
sign_a, sign_b  in  1 each  operand signs
exp_a, exp_b  in  EXP_W each  original (pre-alignment) exponents
mant_a, mant_b  in  MANT_W each  aligned significands
grs_in  in  3  GRS bits of whichever operand had the smaller exponent; ignored when exp_a == exp_b
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
res_mant  out  MANT_W  result significand, bits [MANT_W+2:3] of the extended result
res_grs  out  3  result GRS, bits [2:0] of the extended result
res_carry  out  1  carry out of effective add; always 0 on effective subtract
res_sign  out  1  result sign
res_zero  out  1  extended result is exactly zero
res_exp  out  EXP_W  max(exp_a, exp_b), passed through for the normaliser

Behaviour:
- Handshake:
  - Input accepted when in_valid && in_ready.
  - Output consumed when out_valid && out_ready.
  - Inputs are sampled only at acceptance.
  - Outputs hold stable while out_valid && !out_ready.
- Pipeline, two valid bits s1_v and s2_v:
  - adv2 = !s2_v || out_ready.
  - adv1 = !s1_v || adv2.
  - in_ready = adv1, combinational and with no dependence on in_valid.
  - Throughput 1/cycle. Latency: accepted on edge N, out_valid on edge N+2 when unstalled.
- Stage 1, registered on accept:
  - Form extended operands ext_a / ext_b, MANT_W+3 bits each. The operand with the smaller exponent gets {mant, grs_in}; the other gets {mant, 3'b0}. If exponents are equal, both get 3'b0.
  - Effective sign: sb = sign_b ^ op_sub. eff_sub = sign_a ^ sb.
  - Magnitude order a_ge_b is computed on the full extended values (GRS included), not on mantissas alone.
  - Register ext_a, ext_b, eff_sub, a_ge_b, sign_a, sb, res_exp.
- Stage 2, registered on adv2:
  - Effective add: {carry, ext} = ext_a + ext_b, MANT_W+4-bit sum. res_sign = sign_a.
  - Effective subtract: ext = larger - smaller, never negative. carry = 0. res_sign = a_ge_b ? sign_a : sb.
  - res_zero = (ext == 0).
  - Exact cancellation (eff_sub, ext == 0): res_sign = sign_a & sb, i.e. +0 unless both are -0 (round-to-nearest rule).
- Reset: s1_v, s2_v, out_valid = 0. All datapath registers and outputs = 0. in_ready = 1 on the first cycle after reset deasserts.
- Reset mid-operation: in-flight transactions are discarded, with no partial output.
- Simultaneous in and out handshake with both stages full: both advance in the same cycle with no bubble.
- A stage whose valid is 0 does not update its data registers, to save power.

Optional Feature:
Macro FPADD_OP_STATS_EN.
- Defined: adds ports stat_add, stat_sub, stat_cancel, out 32 bits each, clear on reset.
  - Each counter increments on output handshake when the result was an effective add, an effective subtract, or an exact cancellation respectively. Cancellations also count in stat_sub.
  - Counters saturate at 2^32-1.
- Undefined: ports and counters are absent, and the datapath is identical.

Decomposition:
- Package fp_addsub_pkg holds:
  - typedef s1_t, the packed stage-1 payload.
  - typedef res_t, the packed result.
  - localparam GRS_W = 3.
  - Function ext_w(MANT_W) returning MANT_W+3.
- One natural sub-module, fp_pipe_stage: a generic parametrised valid/ready register slice taking the payload type and width. It is instantiated twice; the datapath logic sits between the instances.

Test Plan:
1. MANT_W=24. A=+0x800000 e127, B=+0x800000 e127, op_sub=0 → res_mant 0x000000, res_carry 1, res_grs 000, res_sign 0, res_exp 127, out_valid 2 cycles after accept.
2. A=+0x800000 e128, B=-0x400000 e127, grs_in=100 → effective subtract; res_mant 0x3FFFFF, res_grs 100, res_carry 0, res_sign 0.
3. A=+0x400000 e127 grs_in=011, B=+0x400000 e128, op_sub=1 → ext_a (0x2000003) < ext_b, so res_mant 0x3FFFFF, res_grs 101, res_sign 1. Confirms GRS is used in the magnitude compare.
4. A=-0x812345 e130, B=-0x812345 e130, op_sub=1 → res_zero 1, res_mant 0, res_sign 0. Repeat with sign_b=0, op_sub=0 (A=-x, B=+x) → res_sign 0.
5. Four back-to-back transactions with out_ready low for 3 cycles from the second output → in_ready falls when both stages are full. No loss or duplication; outputs in order with stable values during the stall.
6. Assert reset with 2 transactions in flight → next cycle out_valid 0, in_ready 1. Under FPADD_OP_STATS_EN the counters read 0, and after scenarios 1–4 without reset stat_add=1, stat_sub=4, stat_cancel=2.
